timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, width of the counter start value and of the event count.
REQ-002 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide cmd_valid  input  1  command request.
REQ-005 SHALL provide cmd_ready  output  1  command accept; a command transfers when cmd_valid & cmd_ready at a rising edge.
REQ-006 SHALL provide cmd_op  input  2  command code: 00 NOP, 01 START, 10 STOP, 11 RELOAD.
REQ-007 SHALL provide cmd_cfg  input  DATA_W+4  configuration word: [DATA_W-1:0] start value, [DATA_W] dir (1=up), [DATA_W+2:DATA_W+1] cks, [DATA_W+3] auto_reload.
REQ-008 SHALL provide overflow  input  1  sticky overflow flag from the counter.
REQ-009 SHALL provide underflow  input  1  sticky underflow flag from the counter.
REQ-010 SHALL provide irq_ack  input  1  interrupt acknowledge, one-cycle pulse.
REQ-011 SHALL provide clk_ena  output  1  counter tick, one-cycle pulse.
REQ-012 SHALL provide start_counter  output  DATA_W  value driven to the counter's load port.
REQ-013 SHALL provide load  output  1  counter load strobe.
REQ-014 SHALL provide up_down  output  1  counter direction, 1=up.
REQ-015 SHALL provide enable  output  1  counter run enable.
REQ-016 SHALL provide clr_overflow and clr_underflow  output  1 each  one-cycle flag-clear pulses to the counter.
REQ-017 SHALL provide irq  output  1  sticky interrupt.
REQ-018 SHALL provide evt_count  output  DATA_W  overflow/underflow event count.

Function
REQ-019 SHALL implement the FSM IDLE, LOAD, RUN, FLAG; all outputs registered except cmd_ready.
REQ-020 cmd_ready SHALL be 1 in IDLE, 1 in RUN only while overflow|underflow is 0, and 0 in LOAD and FLAG.
REQ-021 START accepted in IDLE or RUN, or RELOAD accepted in RUN, SHALL latch cmd_cfg into shadow registers and go to LOAD; RELOAD in IDLE, and NOP in any state, SHALL be accepted with no effect.
REQ-022 LOAD SHALL last exactly one cycle with load=1, enable=0, start_counter=shadow value, up_down=shadow dir, prescaler cleared to 0, then go to RUN.
REQ-023 RUN SHALL drive enable=1 and load=0; prescaler N = 2^(cks+1), i.e. 2, 4, 8 or 16.
REQ-024 In RUN, clk_ena SHALL pulse for one cycle every N cycles, the first pulse occurring in the Nth RUN cycle; the prescaler wraps N-1 -> 0.
REQ-025 clk_ena SHALL be 0 in every state other than RUN.
REQ-026 STOP accepted in RUN SHALL go to IDLE with enable=0 and prescaler cleared; STOP in IDLE SHALL have no effect.
REQ-027 overflow or underflow high in RUN SHALL take priority over any command and go to FLAG.
REQ-028 FLAG SHALL last one cycle: pulse clr_overflow and/or clr_underflow for whichever flags are set, set irq, enable=0; then go to LOAD if auto_reload=1, otherwise to IDLE.
REQ-029 irq SHALL clear on irq_ack; when a set and irq_ack coincide, the set SHALL win.
REQ-030 overflow and underflow both high SHALL pulse both clears in the same FLAG cycle and count as one event.

Reset
REQ-031 rst SHALL force IDLE immediately, mid-operation included: all outputs 0, shadow registers and prescaler 0, up_down=0.
REQ-032 The first rising edge after rst deasserts SHALL behave as IDLE; a command presented there SHALL be accepted.

Configuration
REQ-033 With TIMER_CTRL_EVCNT_EN defined, evt_count SHALL increment once per FLAG entry, saturate at 2^DATA_W-1, and clear on START accepted in IDLE.
REQ-034 Without TIMER_CTRL_EVCNT_EN, evt_count SHALL be constant 0 and contain no counter logic.

Verification
REQ-035 START cfg value=0x00, dir=1, cks=00 -> load=1 for one cycle, start_counter=0x00, then clk_ena every 2 cycles, first in the 2nd RUN cycle.
REQ-036 RUN with cks=11, RELOAD value=50 between ticks -> one LOAD cycle with start_counter=50, prescaler restarts, next clk_ena 16 cycles later.
REQ-037 overflow=1 with auto_reload=1 -> cmd_ready=0 that cycle, clr_overflow pulse, irq=1, LOAD, RUN resumes; with auto_reload=0 -> IDLE, enable=0.
REQ-038 STOP and overflow on the same edge -> FLAG taken and STOP not accepted; irq_ack coincident with a new event -> irq stays 1.
REQ-039 rst asserted in RUN -> all outputs 0 within the same cycle; START after release -> normal LOAD/RUN.
REQ-040 With TIMER_CTRL_EVCNT_EN, 300 overflow events at DATA_W=8 -> evt_count=255; START from IDLE -> evt_count=0.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: command handshake, counter-control and interrupt signals of timer_ctrl
interface timer_ctrl_if #(parameter int DATA_W = 8);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W+3:0] cmd_cfg;
  logic              overflow;
  logic              underflow;
  logic              irq_ack;
  logic              clk_ena;
  logic [DATA_W-1:0] start_counter;
  logic              load;
  logic              up_down;
  logic              enable;
  logic              clr_overflow;
  logic              clr_underflow;
  logic              irq;
  logic [DATA_W-1:0] evt_count;
  modport slave (
    input  cmd_valid, cmd_op, cmd_cfg, overflow, underflow, irq_ack,
    output cmd_ready, clk_ena, start_counter, load, up_down, enable,
           clr_overflow, clr_underflow, irq, evt_count
  );
  modport master (
    output cmd_valid, cmd_op, cmd_cfg, overflow, underflow, irq_ack,
    input  cmd_ready, clk_ena, start_counter, load, up_down, enable,
           clr_overflow, clr_underflow, irq, evt_count
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: command-driven FSM and prescaler controlling an external up/down counter
// Optional saturating event counter is built when TIMER_CTRL_EVCNT_EN is defined.
module timer_ctrl #(parameter int DATA_W = 8) (
  input logic         clk,
  input logic         rst,
  timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLAG} state_t;
  localparam logic [1:0] START = 2'b01, STOP = 2'b10, RELOAD = 2'b11;
  state_t            state_q, state_d;
  logic [DATA_W+3:0] cfg_q, cfg_d;
  logic [3:0]        presc_q, presc_d, presc_max;
  logic              flag, fire, start_idle;
  logic              clk_ena_q, load_q, enable_q, clr_ov_q, clr_un_q, irq_q;
  assign flag          = state_q == RUN && (bus.overflow || bus.underflow);
  assign bus.cmd_ready = state_q == IDLE || (state_q == RUN && !(bus.overflow || bus.underflow));
  assign fire          = bus.cmd_valid && bus.cmd_ready;
  assign start_idle    = state_q == IDLE && fire && bus.cmd_op == START;
  assign presc_max     = 4'((32'd2 << cfg_q[DATA_W+2:DATA_W+1]) - 32'd1);
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    case (state_q)
      IDLE: if (start_idle) begin
        state_d = LOAD;
        cfg_d   = bus.cmd_cfg;
      end
      LOAD: state_d = RUN;
      RUN: if (flag) state_d = FLAG;
      else if (fire && (bus.cmd_op == START || bus.cmd_op == RELOAD)) begin
        state_d = LOAD;
        cfg_d   = bus.cmd_cfg;
      end
      else if (fire && bus.cmd_op == STOP) state_d = IDLE;
      FLAG: state_d = cfg_q[DATA_W+3] ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    // prescaler only advances while staying in RUN; any other state restarts it
    presc_d = state_d == RUN ? (presc_q == presc_max ? 4'd0 : presc_q + 4'd1) : 4'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      presc_q   <= '0;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      clk_ena_q <= 1'b0;
      clr_ov_q  <= 1'b0;
      clr_un_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      presc_q   <= presc_d;
      load_q    <= state_d == LOAD;
      enable_q  <= state_d == RUN;
      clk_ena_q <= state_d == RUN && presc_d == 4'd0;
      clr_ov_q  <= flag && bus.overflow;
      clr_un_q  <= flag && bus.underflow;
      irq_q     <= flag || (irq_q && !bus.irq_ack);
    end
  end
  assign bus.load          = load_q;
  assign bus.enable        = enable_q;
  assign bus.clk_ena       = clk_ena_q;
  assign bus.clr_overflow  = clr_ov_q;
  assign bus.clr_underflow = clr_un_q;
  assign bus.irq           = irq_q;
  assign bus.start_counter = cfg_q[DATA_W-1:0];
  assign bus.up_down       = cfg_q[DATA_W];
`ifdef TIMER_CTRL_EVCNT_EN
  logic [DATA_W-1:0] evt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_q <= '0;
    else if (start_idle) evt_q <= '0;
    else if (flag && evt_q != '1) evt_q <= evt_q + 1'b1;
  end
  assign bus.evt_count = evt_q;
`else
  assign bus.evt_count = '0;
`endif
endmodule
